native2axil_adapter: RTL
========================

// Module: native2axil_adapter
// PURPOSE
//  Bridges a native-interface master (CPU/DMA side) to an AXI4-Lite slave; it is the initiator counterpart of
//  the AXI4-Lite-to-native slave adapter. It accepts one native request at a time, issues it as an AXI4-Lite
//  write (AW+W, then B) or read (AR, then R), and returns a single-cycle native ready with read data.
//  It is non-pipelined, with at most one outstanding transaction.
// PARAMETERS
//  AXIL_ADDR_W  32  address width, bits
//  AXIL_DATA_W  32  data width, bits (must be a multiple of 8)
// PORTS
//  clk             in   1              clock
//  rst             in   1              reset, asynchronous, active-high
//  valid           in   1              native request valid; held high until ready
//  addr            in   AXIL_ADDR_W    native byte address
//  wdata           in   AXIL_DATA_W    native write data
//  wstrb           in   AXIL_DATA_W/8  byte enables; nonzero = write, zero = read
//  rdata           out  AXIL_DATA_W    read data, valid while ready=1 for a read
//  ready           out  1              one-cycle completion pulse
//  m_axil_aw*/w*/b*/ar*/r*  AXI4-Lite master ports, standard widths
//    awprot and arprot are tied to 3'b000
//  err             out  1              response error, present only with NATIVE2AXIL_ERR_EN
// BEHAVIOUR
//  - Reset: async, active-high. state=IDLE; ready, awvalid, wvalid, arvalid, bready, rready = 0; rdata=0; err=0.
//  - All AXI and native outputs are registered. AXI addr/data/strb come from a request latched at acceptance,
//    so they stay stable regardless of native input changes.
//  - FSM states:
//    - IDLE: if valid & ~ready, latch addr/wdata/wstrb.
//      - If wstrb!=0: go to WRITE; set awvalid=1, wvalid=1.
//      - Else: go to RD_ADDR; set arvalid=1.
//      - valid is ignored in the cycle ready=1; the native master drops or replaces the request after ready.
//    - WRITE: clear awvalid on awvalid&awready; clear wvalid on wvalid&wready, independently and in any order
//      (same cycle allowed). Once both handshakes are done, go to W_RESP with bready=1.
//    - W_RESP: on bvalid&bready, clear bready, pulse ready=1 next cycle, go to IDLE.
//    - RD_ADDR: on arvalid&arready, clear arvalid, go to RD_DATA with rready=1.
//    - RD_DATA: on rvalid&rready, rdata<=m_axil_rdata, clear rready, pulse ready=1 next cycle, go to IDLE.
//  - ready: high exactly 1 cycle per request. rdata holds its value until the next read completes.
//  - Minimum latency with a zero-wait slave: 3 cycles for write and for read (accept, address/data handshake,
//    response handshake, then ready).
//  - awvalid, wvalid and arvalid are never withdrawn before their handshake (AXI rule).
//  - Back-to-back requests: a new request is accepted at the earliest in the cycle after the ready pulse.
//  - Reset mid-transaction: all valids and readies drop immediately and the transaction is abandoned. The
//    AXI slave must share the reset.
//  - bresp and rresp are ignored unless NATIVE2AXIL_ERR_EN is defined.
// CONFIGURATION
//  - NATIVE2AXIL_ERR_EN defined: adds output err.
//    - err is registered with ready: err = (bresp!=2'b00) for writes, (rresp!=2'b00) for reads.
//    - err is 0 when ready=0.
//  - NATIVE2AXIL_ERR_EN undefined: no err port; responses are treated as OKAY.
// STRUCTURE
//  - Shared header (axi.vh): AXI4-Lite port macros (master flavour), AXI_RESP_W, AXI_PROT_W.
//  - Package constants: state encodings IDLE, WRITE, W_RESP, RD_ADDR, RD_DATA (3 bits); OKAY response value.
//  - Single module, no sub-module. Register instances use the codebase's standard register primitive with async reset.
// TESTING
//  1. Write, zero-wait slave: addr=0x10, wdata=0xA5A5_0001, wstrb=0xF -> awaddr=0x10, wdata and wstrb match;
//     ready on cycle 3; the slave memory word updates.
//  2. Read after write: addr=0x10, wstrb=0 -> araddr=0x10; rdata=0xA5A5_0001 with ready on cycle 3.
//  3. Skewed write channels: wready 4 cycles before awready, then the reverse; also both in the same cycle ->
//     exactly one AW and one W handshake each; bready rises only after both.
//  4. Backpressure: arready delayed 5 cycles, rvalid delayed 3 cycles -> arvalid, araddr stable throughout;
//     ready=1 for exactly 1 cycle.
//  5. Reset asserted in W_RESP -> bready, ready, all valids = 0 asynchronously; next request is accepted normally.
//  6. With NATIVE2AXIL_ERR_EN: slave returns bresp=2'b10 -> err=1 with ready; OKAY read -> err=0.

Source files
------------

// File: rtl/native2axil_adapter_pkg.sv
// native2axil_adapter_pkg: shared AXI4-Lite widths, response codes and FSM state encodings
package native2axil_adapter_pkg;

   localparam int AXI_RESP_W = 2;
   localparam int AXI_PROT_W = 3;

   localparam logic [AXI_RESP_W-1:0] AXI_OKAY = 2'b00;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      W_RESP  = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4
   } state_t;

endpackage

// File: rtl/native2axil_adapter.sv
// native2axil_adapter: native request/ready master to AXI4-Lite master bridge, one transaction in flight.
// Optional response error output enabled by defining NATIVE2AXIL_ERR_EN.
module native2axil_adapter
   import native2axil_adapter_pkg::*;
#(
   parameter int AXIL_ADDR_W = 32,
   parameter int AXIL_DATA_W = 32
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid,
   input  logic [AXIL_ADDR_W-1:0]     addr,
   input  logic [AXIL_DATA_W-1:0]     wdata,
   input  logic [AXIL_DATA_W/8-1:0]   wstrb,
   output logic [AXIL_DATA_W-1:0]     rdata,
   output logic                       ready,
   output logic [AXIL_ADDR_W-1:0]     m_axil_awaddr,
   output logic [AXI_PROT_W-1:0]      m_axil_awprot,
   output logic                       m_axil_awvalid,
   input  logic                       m_axil_awready,
   output logic [AXIL_DATA_W-1:0]     m_axil_wdata,
   output logic [AXIL_DATA_W/8-1:0]   m_axil_wstrb,
   output logic                       m_axil_wvalid,
   input  logic                       m_axil_wready,
   input  logic [AXI_RESP_W-1:0]      m_axil_bresp,
   input  logic                       m_axil_bvalid,
   output logic                       m_axil_bready,
   output logic [AXIL_ADDR_W-1:0]     m_axil_araddr,
   output logic [AXI_PROT_W-1:0]      m_axil_arprot,
   output logic                       m_axil_arvalid,
   input  logic                       m_axil_arready,
   input  logic [AXIL_DATA_W-1:0]     m_axil_rdata,
   input  logic [AXI_RESP_W-1:0]      m_axil_rresp,
   input  logic                       m_axil_rvalid,
   output logic                       m_axil_rready
`ifdef NATIVE2AXIL_ERR_EN
   ,
   output logic                       err
`endif
);

   localparam int STRB_W = AXIL_DATA_W / 8;

   state_t                 r_state, w_state;
   logic                   r_awvalid, w_awvalid;
   logic                   r_wvalid, w_wvalid;
   logic                   r_bready, w_bready;
   logic                   r_arvalid, w_arvalid;
   logic                   r_rready, w_rready;
   logic                   r_ready, w_ready;
   logic [AXIL_ADDR_W-1:0] r_addr, w_addr;
   logic [AXIL_DATA_W-1:0] r_wdata, w_wdata;
   logic [STRB_W-1:0]      r_wstrb, w_wstrb;
   logic [AXIL_DATA_W-1:0] r_rdata, w_rdata;
   logic                   w_aw_done, w_w_done;

   assign w_aw_done = ~r_awvalid | m_axil_awready;
   assign w_w_done  = ~r_wvalid | m_axil_wready;

   // next-state and next-output logic; a request is only taken when no completion pulse is on the wire
   always_comb begin
      w_state   = r_state;
      w_awvalid = r_awvalid;
      w_wvalid  = r_wvalid;
      w_bready  = r_bready;
      w_arvalid = r_arvalid;
      w_rready  = r_rready;
      w_ready   = 1'b0;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      w_wstrb   = r_wstrb;
      w_rdata   = r_rdata;
      case (r_state)
         IDLE: if (valid && !r_ready) begin
            w_addr    = addr;
            w_wdata   = wdata;
            w_wstrb   = wstrb;
            w_state   = (|wstrb) ? WRITE : RD_ADDR;
            w_awvalid = |wstrb;
            w_wvalid  = |wstrb;
            w_arvalid = ~|wstrb;
         end
         WRITE: begin
            w_awvalid = r_awvalid & ~m_axil_awready;
            w_wvalid  = r_wvalid & ~m_axil_wready;
            if (w_aw_done && w_w_done) begin
               w_state  = W_RESP;
               w_bready = 1'b1;
            end
         end
         W_RESP: if (m_axil_bvalid) begin
            w_bready = 1'b0;
            w_ready  = 1'b1;
            w_state  = IDLE;
         end
         RD_ADDR: if (m_axil_arready) begin
            w_arvalid = 1'b0;
            w_rready  = 1'b1;
            w_state   = RD_DATA;
         end
         RD_DATA: if (m_axil_rvalid) begin
            w_rdata  = m_axil_rdata;
            w_rready = 1'b0;
            w_ready  = 1'b1;
            w_state  = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

   // state and every outward-facing signal are registered; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_ready   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
      end else begin
         r_state   <= w_state;
         r_awvalid <= w_awvalid;
         r_wvalid  <= w_wvalid;
         r_bready  <= w_bready;
         r_arvalid <= w_arvalid;
         r_rready  <= w_rready;
         r_ready   <= w_ready;
         r_addr    <= w_addr;
         r_wdata   <= w_wdata;
         r_wstrb   <= w_wstrb;
         r_rdata   <= w_rdata;
      end
   end

   assign ready          = r_ready;
   assign rdata          = r_rdata;
   assign m_axil_awaddr  = r_addr;
   assign m_axil_awprot  = '0;
   assign m_axil_awvalid = r_awvalid;
   assign m_axil_wdata   = r_wdata;
   assign m_axil_wstrb   = r_wstrb;
   assign m_axil_wvalid  = r_wvalid;
   assign m_axil_bready  = r_bready;
   assign m_axil_araddr  = r_addr;
   assign m_axil_arprot  = '0;
   assign m_axil_arvalid = r_arvalid;
   assign m_axil_rready  = r_rready;

`ifdef NATIVE2AXIL_ERR_EN
   logic r_err;

   // err rides alongside the ready pulse and reflects the response that closed the transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else
         r_err <= (r_state == W_RESP && m_axil_bvalid) ? (m_axil_bresp != AXI_OKAY) :
                  (r_state == RD_DATA && m_axil_rvalid) ? (m_axil_rresp != AXI_OKAY) : 1'b0;
   end

   assign err = r_err;
`else
   logic w_unused_resp;

   assign w_unused_resp = ^{m_axil_bresp, m_axil_rresp};
`endif

endmodule
